// File: rtl/midi_pkg.sv
// Shared constants and encodings for the MIDI note decoder slice.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [2:0] {
    PS_IDLE    = 3'b001,
    PS_WAIT_D1 = 3'b010,
    PS_WAIT_D2 = 3'b100
  } parse_state_e;

  typedef enum logic [2:0] {
    RK_NONE,
    RK_NOTE_OFF,
    RK_NOTE_ON,
    RK_CC,
    RK_SKIP1,
    RK_SKIP2
  } run_kind_e;

  typedef enum logic [1:0] {
    BC_DATA,
    BC_CHAN_STATUS,
    BC_SYS_COMMON,
    BC_REALTIME
  } byte_class_e;

endpackage

// File: rtl/midi_byte_classify.sv
// Combinational classifier: byte class plus the running kind a status byte would select.
module midi_byte_classify
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic [7:0]  byte_i,
  output byte_class_e cls_o,
  output run_kind_e   kind_o
);

  logic [3:0] hiNib;
  logic       chanMatch;

  assign hiNib     = byte_i[7:4];
  assign chanMatch = (byte_i[3:0] == CHANNEL);

  always_comb begin
    cls_o = BC_DATA;
    if (!byte_i[7])
      cls_o = BC_DATA;
    else if (hiNib != 4'hF)
      cls_o = BC_CHAN_STATUS;
    else if (byte_i[3])
      cls_o = BC_REALTIME;
    else
      cls_o = BC_SYS_COMMON;
  end

  // Program change / channel pressure carry one data byte regardless of channel.
  always_comb begin
    kind_o = RK_NONE;
    if (byte_i[7] && hiNib != 4'hF) begin
      if (hiNib == ST_PROG || hiNib == ST_CHPRESS)
        kind_o = RK_SKIP1;
      else if (chanMatch && hiNib == ST_NOTE_OFF)
        kind_o = RK_NOTE_OFF;
      else if (chanMatch && hiNib == ST_NOTE_ON)
        kind_o = RK_NOTE_ON;
      else if (chanMatch && hiNib == ST_CC)
        kind_o = RK_CC;
      else
        kind_o = RK_SKIP2;
    end
  end

endmodule

// File: rtl/midi_note_decoder.sv
// Serial-MIDI parser producing monophonic note_on/note_off strobes, gate, note and velocity.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL   = 4'd0,
  parameter bit         RETRIGGER = 1'b1
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       note_on,
  output logic       note_off,
  output logic       gate,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic [7:0] drop_cnt
);

  byte_class_e  byteCls;
  run_kind_e    byteKind;
  parse_state_e state_q, state_d;
  run_kind_e    kind_q, kind_d;
  logic [6:0]   d1_q, d1_d;
  logic [6:0]   note_q, note_d;
  logic [6:0]   vel_q, vel_d;
  logic         gate_q, gate_d;
  logic         on_q, on_d;
  logic         off_q, off_d;
  logic [7:0]   drop_q, drop_d;
  logic [6:0]   dataByte;

  midi_byte_classify #(.CHANNEL(CHANNEL)) u_classify (
    .byte_i (rx_data),
    .cls_o  (byteCls),
    .kind_o (byteKind)
  );

  assign dataByte = rx_data[6:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= PS_IDLE;
      kind_q  <= RK_NONE;
      d1_q    <= '0;
      note_q  <= '0;
      vel_q   <= '0;
      gate_q  <= 1'b0;
      on_q    <= 1'b0;
      off_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      d1_q    <= d1_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
      gate_q  <= gate_d;
      on_q    <= on_d;
      off_q   <= off_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    d1_d    = d1_q;
    note_d  = note_q;
    vel_d   = vel_q;
    gate_d  = gate_q;
    on_d    = 1'b0;
    off_d   = 1'b0;
    drop_d  = drop_q;
    if (rx_valid) begin
      unique case (byteCls)
        BC_REALTIME: ;
        BC_SYS_COMMON: begin
          kind_d  = RK_NONE;
          state_d = PS_IDLE;
        end
        // Any channel status restarts the message, discarding a partial one.
        BC_CHAN_STATUS: begin
          kind_d  = byteKind;
          state_d = PS_WAIT_D1;
        end
        BC_DATA: begin
          unique case (state_q)
            PS_IDLE: begin
              if (drop_q != 8'hFF)
                drop_d = drop_q + 8'd1;
            end
            PS_WAIT_D1: begin
              d1_d    = dataByte;
              state_d = (kind_q == RK_SKIP1) ? PS_WAIT_D1 : PS_WAIT_D2;
            end
            PS_WAIT_D2: begin
              state_d = PS_WAIT_D1;
              if (kind_q == RK_NOTE_ON && dataByte != 7'd0) begin
                note_d = d1_q;
                vel_d  = dataByte;
                gate_d = 1'b1;
                on_d   = !gate_q || RETRIGGER;
              end else if (kind_q == RK_NOTE_OFF || kind_q == RK_NOTE_ON) begin
                if (gate_q && d1_q == note_q) begin
                  gate_d = 1'b0;
                  off_d  = 1'b1;
                end
              end else if (kind_q == RK_CC && d1_q == CC_ALL_NOTES_OFF && gate_q) begin
                gate_d = 1'b0;
                off_d  = 1'b1;
              end
            end
            default: state_d = PS_IDLE;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign note_on  = on_q;
  assign note_off = off_q;
  assign gate     = gate_q;
  assign note     = note_q;
  assign velocity = vel_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed bench for midi_note_decoder: two instances share one byte stream, differing only in RETRIGGER.
module tb_midi_note_decoder;

  logic       clk;
  logic       rst_b;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic       onA, offA, gateA;
  logic [6:0] noteA, velA;
  logic [7:0] dropA;
  logic       onB, offB, gateB;
  logic [6:0] noteB, velB;
  logic [7:0] dropB;

  int vectors = 0;
  int miscompares = 0;

  midi_note_decoder #(.CHANNEL(4'd0), .RETRIGGER(1'b1)) dutA (
    .clk(clk), .rst_b(rst_b), .rx_data(rx_data), .rx_valid(rx_valid),
    .note_on(onA), .note_off(offA), .gate(gateA),
    .note(noteA), .velocity(velA), .drop_cnt(dropA)
  );

  midi_note_decoder #(.CHANNEL(4'd0), .RETRIGGER(1'b0)) dutB (
    .clk(clk), .rst_b(rst_b), .rx_data(rx_data), .rx_valid(rx_valid),
    .note_on(onB), .note_off(offB), .gate(gateB),
    .note(noteB), .velocity(velB), .drop_cnt(dropB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one byte for exactly one clock; returns #1 after the capturing edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst_b    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_note_on", 32'(onA), 32'd0);
    checkOutput("rst_note_off", 32'(offA), 32'd0);
    checkOutput("rst_gate", 32'(gateA), 32'd0);
    checkOutput("rst_note", 32'(noteA), 32'd0);
    checkOutput("rst_velocity", 32'(velA), 32'd0);
    checkOutput("rst_drop", 32'(dropA), 32'd0);
    rst_b = 1'b1;
    tick();

    // Basic note on / note off
    applyStimulus(8'h90); applyStimulus(8'h3C);
    checkOutput("t1_no_early_on", 32'(onA), 32'd0);
    applyStimulus(8'h64);
    checkOutput("t1_on_pulse", 32'(onA), 32'd1);
    checkOutput("t1_on_pulse_b", 32'(onB), 32'd1);
    checkOutput("t1_note", 32'(noteA), 32'd60);
    checkOutput("t1_vel", 32'(velA), 32'd100);
    checkOutput("t1_gate", 32'(gateA), 32'd1);
    tick();
    checkOutput("t1_on_one_cycle", 32'(onA), 32'd0);
    applyStimulus(8'h80); applyStimulus(8'h3C); applyStimulus(8'h40);
    checkOutput("t1_off_pulse", 32'(offA), 32'd1);
    checkOutput("t1_off_gate", 32'(gateA), 32'd0);
    checkOutput("t1_off_note_kept", 32'(noteA), 32'd60);
    checkOutput("t1_off_no_on", 32'(onA), 32'd0);
    tick();
    checkOutput("t1_off_one_cycle", 32'(offA), 32'd0);

    // Running status with retrigger difference
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
    checkOutput("t2_on60", 32'(onA), 32'd1);
    applyStimulus(8'h40); applyStimulus(8'h50);
    checkOutput("t2_retrig_a", 32'(onA), 32'd1);
    checkOutput("t2_retrig_b", 32'(onB), 32'd0);
    checkOutput("t2_note64", 32'(noteA), 32'd64);
    checkOutput("t2_note64_b", 32'(noteB), 32'd64);
    checkOutput("t2_vel80", 32'(velA), 32'd80);
    applyStimulus(8'h40); applyStimulus(8'h00);
    checkOutput("t2_vel0_off", 32'(offA), 32'd1);
    checkOutput("t2_vel0_no_on", 32'(onA), 32'd0);
    checkOutput("t2_gate", 32'(gateA), 32'd0);
    checkOutput("t2_vel_kept", 32'(velA), 32'd80);
    tick();

    // Real-time bytes interleaved
    applyStimulus(8'h90); applyStimulus(8'hF8); applyStimulus(8'h3C);
    applyStimulus(8'hFE);
    checkOutput("t3_no_early_on", 32'(onA), 32'd0);
    applyStimulus(8'h64);
    checkOutput("t3_on", 32'(onA), 32'd1);
    checkOutput("t3_note", 32'(noteA), 32'd60);
    checkOutput("t3_gate", 32'(gateA), 32'd1);
    tick();
    checkOutput("t3_single_pulse", 32'(onA), 32'd0);
    applyStimulus(8'h3C); applyStimulus(8'h00);
    checkOutput("t3_release", 32'(offA), 32'd1);
    tick();

    // Channel filter
    applyStimulus(8'h91); applyStimulus(8'h3C); applyStimulus(8'h64);
    checkOutput("t4_ch1_no_on", 32'(onA), 32'd0);
    checkOutput("t4_ch1_gate", 32'(gateA), 32'd0);
    applyStimulus(8'h45); applyStimulus(8'h30);
    checkOutput("t4_rs_no_on", 32'(onA), 32'd0);
    checkOutput("t4_rs_note", 32'(noteA), 32'd60);
    checkOutput("t4_rs_drop", 32'(dropA), 32'd0);

    // Drops, abort, program change skip, all-notes-off
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
    applyStimulus(8'h3C);
    checkOutput("t5_drop1", 32'(dropA), 32'd1);
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'hC0);
    applyStimulus(8'h05);
    checkOutput("t5_pc_no_on", 32'(onA), 32'd0);
    checkOutput("t5_pc_gate", 32'(gateA), 32'd0);
    applyStimulus(8'h90); applyStimulus(8'h3E); applyStimulus(8'h7F);
    checkOutput("t5_on", 32'(onA), 32'd1);
    checkOutput("t5_note", 32'(noteA), 32'd62);
    checkOutput("t5_vel", 32'(velA), 32'd127);
    applyStimulus(8'hB0); applyStimulus(8'h7B); applyStimulus(8'h00);
    checkOutput("t5_ano_off", 32'(offA), 32'd1);
    checkOutput("t5_ano_gate", 32'(gateA), 32'd0);
    checkOutput("t5_drop_kept", 32'(dropA), 32'd1);
    applyStimulus(8'hF0); applyStimulus(8'h3C);
    checkOutput("t5_syscom_drop", 32'(dropA), 32'd2);
    for (int i = 0; i < 260; i++) applyStimulus(8'h11);
    checkOutput("t5_drop_sat", 32'(dropA), 32'd255);

    // Non-matching release and async reset mid-message
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
    checkOutput("t6_on60_b", 32'(onB), 32'd1);
    applyStimulus(8'h40); applyStimulus(8'h40);
    checkOutput("t6_no_retrig_b", 32'(onB), 32'd0);
    checkOutput("t6_note64_b", 32'(noteB), 32'd64);
    applyStimulus(8'h80); applyStimulus(8'h3C); applyStimulus(8'h00);
    checkOutput("t6_nomatch_off", 32'(offB), 32'd0);
    checkOutput("t6_nomatch_gate", 32'(gateB), 32'd1);
    checkOutput("t6_nomatch_note", 32'(noteB), 32'd64);
    applyStimulus(8'h90); applyStimulus(8'h3E);
    #2;
    rst_b = 1'b0;
    #1;
    checkOutput("t6_async_gate_a", 32'(gateA), 32'd0);
    checkOutput("t6_async_gate_b", 32'(gateB), 32'd0);
    checkOutput("t6_async_note", 32'(noteB), 32'd0);
    checkOutput("t6_async_vel", 32'(velB), 32'd0);
    checkOutput("t6_async_drop", 32'(dropA), 32'd0);
    checkOutput("t6_async_on", 32'(onB), 32'd0);
    tick();
    rst_b = 1'b1;
    applyStimulus(8'h7F);
    checkOutput("t6_partial_lost", 32'(dropA), 32'd1);
    checkOutput("t6_partial_no_on", 32'(onA), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/midi_note_decoder.md
Name: midi_note_decoder

Overview:
Parses a serial-MIDI byte stream from the UART receiver and produces the monophonic note_on/note_off strobes that trigger envelope_generator. It also provides the held note number and velocity for the oscillator and envelope stages. It handles running status, real-time byte interleaving, velocity-0 note-off and "All Notes Off" (CC 123) on one configured channel. Position: uart_rx -> midi_note_decoder -> envelope_generator / oscillator.

Parameters:
CHANNEL, 4'd0, MIDI channel (0-15) accepted; all other channels are parsed and discarded.
RETRIGGER, 1, 1 = a note-on while gate is high pulses note_on again; 0 = only note/velocity update, no pulse.

Ports:
clk  input  1  system clock
rst_b  input  1  reset; asynchronous, active-low; clock clk
rx_data  input  8  received MIDI byte
rx_valid  input  1  one-cycle strobe, rx_data valid; no backpressure, any spacing including back-to-back cycles
note_on  output  1  one-cycle pulse: new note started
note_off  output  1  one-cycle pulse: held note released
gate  output  1  level: a note is currently held
note  output  7  current/last note number
velocity  output  7  velocity of current/last note-on
drop_cnt  output  8  saturating count of data bytes received with no running status

Behaviour:
- Reset (async): note_on=0, note_off=0, gate=0, note=0, velocity=0, drop_cnt=0, running status=NONE, parser in IDLE.
- Bytes are processed only in cycles with rx_valid=1. All outputs are registered. A pulse asserts in the cycle after the rx_valid cycle carrying the completing data byte, and lasts exactly 1 cycle.
- Byte classes:
  - real-time: 0xF8-0xFF. Ignored entirely; parser state and partial message are untouched.
  - system common: 0xF0-0xF7. Running status=NONE; parser goes to IDLE. Subsequent data bytes are dropped until a new channel status byte.
  - channel status: 0x80-0xEF. Latched as running status. Kind is decoded from the high nibble and channel match:
    - NOTE_OFF: 0x8n, n = CHANNEL.
    - NOTE_ON: 0x9n, n = CHANNEL.
    - CC: 0xBn, n = CHANNEL.
    - SKIP1: 0xC/0xD, or any non-matching channel with 1 data byte.
    - SKIP2: all other kinds, 2 data bytes.
    - A status byte arriving mid-message aborts the partial message without any output.
  - data: 0x00-0x7F.
- FSM states:
  - IDLE (no running status): a data byte increments drop_cnt (saturating at 255); a channel status byte -> WAIT_D1.
  - WAIT_D1: a data byte is stored as d1. SKIP1 -> completes, stays in WAIT_D1. Otherwise -> WAIT_D2.
  - WAIT_D2: a data byte is stored as d2; the message completes; -> WAIT_D1 (running status retained).
- Completed-message actions (2-byte kinds):
  - NOTE_ON with d2 != 0: note=d1, velocity=d2, gate=1.
    - note_on pulses if gate was 0.
    - If gate was 1, note_on pulses only when RETRIGGER=1.
  - NOTE_ON with d2 = 0: treated as NOTE_OFF d1.
  - NOTE_OFF d1: if gate=1 and d1=note -> gate=0, note_off pulse. Otherwise no effect (note and velocity are kept). The release velocity is ignored.
  - CC with d1=123: if gate=1 -> gate=0, note_off pulse. Other CC numbers, and SKIP kinds, have no effect.
- note_on and note_off are never asserted in the same cycle.
- Last-note priority, no note stack: releasing an earlier-pressed key while a later one is held does nothing.
- Reset mid-message: all state is cleared; the partial message is lost; gate drops immediately (async).

Decomposition:
- Shared package midi_pkg:
  - status nibble constants: 4'h8, 4'h9, 4'hB, 4'hC, 4'hD.
  - CC_ALL_NOTES_OFF = 7'd123.
  - parser state one-hot constants: IDLE, WAIT_D1, WAIT_D2.
  - running-kind encoding: NONE, NOTE_OFF, NOTE_ON, CC, SKIP1, SKIP2.
- One sub-module: midi_byte_classify. Combinational; maps rx_data + CHANNEL to a byte class and a running kind.
- FSM and note-tracking registers stay in the top module.

Test Plan:
1. 0x90,0x3C,0x64 -> note_on pulse 1 cycle after 3rd byte; note=60, velocity=100, gate=1. Then 0x80,0x3C,0x40 -> note_off pulse, gate=0, note stays 60.
2. Running status: 0x90,0x3C,0x64,0x40,0x50,0x40,0x00 (RETRIGGER=1) -> note_on pulse for 60, note_on pulse for 64 (velocity=80), then note_off pulse (velocity-0 on note 64); gate=0.
3. Interleaved real-time: 0x90,0xF8,0x3C,0xFE,0x64 -> single note_on, note=60; no disruption.
4. Channel filter: CHANNEL=0, send 0x91,0x3C,0x64 -> no pulses, gate=0. Then 0x45,0x30 (running status on ch1) -> still no pulses.
5. Abort and drop: after reset send 0x3C -> drop_cnt=1. Then 0x90,0x3C,0xC0,0x05,0x90,0x3E,0x7F -> only one note_on, note=62, velocity=127 (program change skipped). Then 0xB0,0x7B,0x00 -> note_off pulse, gate=0.
6. Non-matching release and reset: note-on 60, then note-on 64 (RETRIGGER=0: no second pulse, note=64). 0x80,0x3C,0x00 -> no effect, gate=1. Assert rst_b=0 mid-message -> gate=0 and all outputs 0 without waiting for clk.
